// File: rtl/i2c_glitch_filter_pkg.sv
// Shared constants for the I2C input glitch filter: channel roles, default
// rejection window and the idle-high synchroniser reset value.
package i2c_filt_pkg;

   localparam int   SCL_CH       = 0;
   localparam int   SDA_CH       = 1;
   localparam int   DEF_FILT_LEN = 8;
   localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter_if.sv
// Bundle of the filter's line inputs, window setting and filtered outputs.
// The slave side is the filter itself; the master side is the controller/IOB side.
interface i2c_glitch_filter_if #(
   parameter int NCH   = 2,
   parameter int CNT_W = 4
);

   logic [NCH-1:0]   in;
   logic [CNT_W-1:0] filt_len;
   logic [NCH-1:0]   out;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   fall;
   logic             start_det;
   logic             stop_det;
   logic             bus_busy;

   modport master (
      output in, filt_len,
      input  out, rise, fall, start_det, stop_det, bus_busy
   );

   modport slave (
      input  in, filt_len,
      output out, rise, fall, start_det, stop_det, bus_busy
   );

endinterface

// File: rtl/i2c_glitch_filter_chan.sv
// One filtered line: synchroniser, persistence counter and edge strobes.
// The *_nxt outputs expose the strobes one cycle early for registered consumers.
module i2c_filt_chan
   import i2c_filt_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             raw,
   input  logic [CNT_W-1:0] filt_len,
   output logic             level,
   output logic             rise,
   output logic             fall,
   output logic             rise_nxt,
   output logic             fall_nxt
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("i2c_filt_chan: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       eff_len_m1;
   logic                   s;
   logic                   toggle;

   assign s = sync[SYNC_STAGES-1];

   // A zero window behaves like a one-cycle window
   always_comb begin
      eff_len_m1 = (filt_len == '0) ? '0 : filt_len - ONE;
      toggle     = (s != level) && (cnt >= eff_len_m1);
   end

   assign rise_nxt = toggle & s;
   assign fall_nxt = toggle & ~s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= {SYNC_STAGES{SYNC_RST_VAL}};
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         rise <= rise_nxt;
         fall <= fall_nxt;
         if (s == level) begin
            cnt <= '0;
         end else if (toggle) begin
            level <= s;
            cnt   <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/i2c_glitch_filter.sv
// Multi-channel I2C line filter with optional START/STOP detection on SCL/SDA.
// Define I2C_COND_DET_EN to build the detector; otherwise its outputs are tied low.
module i2c_glitch_filter
   import i2c_filt_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   i2c_glitch_filter_if.slave  bus
);

   logic [NCH-1:0] out_w;
   logic [NCH-1:0] rise_w;
   logic [NCH-1:0] fall_w;
   logic [NCH-1:0] rise_nxt;
   logic [NCH-1:0] fall_nxt;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      i2c_filt_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .raw      (bus.in[i]),
         .filt_len (bus.filt_len),
         .level    (out_w[i]),
         .rise     (rise_w[i]),
         .fall     (fall_w[i]),
         .rise_nxt (rise_nxt[i]),
         .fall_nxt (fall_nxt[i])
      );
   end

   assign bus.out  = out_w;
   assign bus.rise = rise_w;
   assign bus.fall = fall_w;

`ifdef I2C_COND_DET_EN
   if (NCH < 2) begin : g_bad_nch
      $error("i2c_glitch_filter: START/STOP detection needs NCH >= 2");
   end

   logic start_q;
   logic stop_q;
   logic busy_q;
   logic cond_ok;

   // SDA edges count only with SCL already high and not itself moving this cycle
   always_comb begin
      cond_ok = out_w[SCL_CH] && !rise_nxt[SCL_CH] && !fall_nxt[SCL_CH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         start_q <= cond_ok && fall_nxt[SDA_CH];
         stop_q  <= cond_ok && rise_nxt[SDA_CH];
         if (cond_ok && fall_nxt[SDA_CH]) begin
            busy_q <= 1'b1;
         end else if (cond_ok && rise_nxt[SDA_CH]) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign bus.start_det = start_q;
   assign bus.stop_det  = stop_q;
   assign bus.bus_busy  = busy_q;
`else
   logic unused_nxt;
   assign unused_nxt = ^{rise_nxt, fall_nxt};

   assign bus.start_det = 1'b0;
   assign bus.stop_det  = 1'b0;
   assign bus.bus_busy  = 1'b0;
`endif

endmodule

// File: doc/i2c_glitch_filter.md
# i2c_glitch_filter

Parametrised multi-channel noise filter for the FMC424 I2C controller's open-drain inputs (SCL, SDA, and any extra lines). Each channel has a metastability synchroniser and a counter-based persistence filter with a run-time programmable rejection window, plus registered rise/fall strobes. An optional START/STOP detector on channels 0/1 supplies bus-condition pulses and a busy flag to the controller FSM. The block sits between the IOB input buffers and the I2C controller, clocked by the 156.25 MHz system clock.

## Interface
- `NCH`, 2: number of filtered channels. Channel 0 is SCL and channel 1 is SDA when START/STOP detection is compiled in.
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `CNT_W`, 4: width of the filter counter and of `filt_len`.
- `clk`  in  1  system clock, 156.25 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `in`  in  NCH  raw asynchronous line inputs.
- `filt_len`  in  CNT_W  rejection window in clk cycles; quasi-static; 0 is treated as 1.
- `out`  out  NCH  filtered levels.
- `rise`  out  NCH  1-cycle pulse, concurrent with `out[i]` going 0→1.
- `fall`  out  NCH  1-cycle pulse, concurrent with `out[i]` going 1→0.
- `start_det`  out  1  1-cycle START pulse (macro only; otherwise tied 0).
- `stop_det`  out  1  1-cycle STOP pulse (macro only; otherwise tied 0).
- `bus_busy`  out  1  high between START and STOP (macro only; otherwise tied 0).

## Operation
- Reset values: all synchroniser flops = 1, since the I2C bus idles high; `out` = all 1s; counters = 0; `rise`, `fall`, `start_det`, `stop_det`, `bus_busy` = 0.
- Per channel: `s[i]` is the last synchroniser stage.
  - If `s[i] == out[i]`: counter cleared.
  - Else, if `cnt >= eff_len-1` (where `eff_len = max(filt_len,1)`): `out[i] <= s[i]`, counter cleared, and `rise[i]` or `fall[i]` asserted for that cycle.
  - Otherwise the counter increments, saturating at all-ones.
- A mismatch shorter than `eff_len` consecutive cycles at `s[i]` never reaches `out[i]`. Any single matching cycle restarts the count.
- Changing `filt_len` mid-count takes effect immediately. The `>=` compare guarantees a toggle on the next mismatching cycle if the new window is already exceeded.
- START/STOP detector, qualified on previous-cycle `out[0]==1` and no SCL edge in the same cycle:
  - `fall[1]` → `start_det`, `bus_busy <= 1`.
  - `rise[1]` → `stop_det`, `bus_busy <= 0`.
- Repeated START while busy: `start_det` pulses and `bus_busy` stays 1.
- Simultaneous SCL and SDA edges: no condition flagged.
- Reset asserted mid-filter: all state returns to reset values asynchronously. There are no pulses on release.

## Timing
- Latency from `in[i]` change (stable, sampled at edge k) to `out[i]` change: `SYNC_STAGES + eff_len` clk edges.
- `rise`, `fall`, `start_det` and `stop_det` are registered outputs, high exactly one cycle and aligned with the `out` transition cycle.
- `bus_busy` updates in the same cycle as `start_det` / `stop_det`.
- Default `filt_len`=8 gives a 51.2 ns rejection window, meeting the I2C 50 ns spike requirement.

## Configuration
- `I2C_COND_DET_EN` defined:
  - START/STOP detector and `bus_busy` logic present.
  - Elaboration error if `NCH < 2`.
- `I2C_COND_DET_EN` undefined:
  - `start_det`, `stop_det` and `bus_busy` tied to 0.
  - No detector flops.
  - Ports remain present.

## Structure
- Package `i2c_filt_pkg`:
  - `SCL_CH`=0, `SDA_CH`=1.
  - `DEF_FILT_LEN`=8.
  - `SYNC_RST_VAL`=1'b1.
- Sub-module `i2c_filt_chan`: one synchroniser, counter and edge-strobe pipeline, instantiated `NCH` times by generate loop.
- The START/STOP detector lives in the top level.

## Test plan
- Reset: hold `rst_n`=0 with `in`=2'b00 → `out`=2'b11 and all strobes 0. Release → after 2+8 cycles, `out`=2'b00, with `fall`=2'b11 pulsed once.
- Glitch reject: `filt_len`=8, SDA low pulse of 7 cycles → `out[1]` stays 1, no `fall[1]`. A pulse of 8 cycles → `out[1]` falls exactly 10 cycles after the input edge.
- `filt_len`=0 with a 1-cycle pulse → passes through as a 1-cycle `out` pulse with 3-cycle latency. `filt_len` reduced 8→3 while the counter is at 5 → toggle on the next mismatching cycle.
- START/STOP: SCL high, SDA 1→0 → single `start_det`, `bus_busy`=1. SDA 0→1 → `stop_det`, `bus_busy`=0. SDA edge while SCL low → no pulses.
- Simultaneous SCL 1→0 and SDA 1→0 → no `start_det`. Assert `rst_n` while `bus_busy`=1 → `bus_busy`=0 immediately.
